cpu_clock_enable_gen: RTL and testbench
=======================================

Name: cpu_clock_enable_gen

Overview:
- Parametrised successor to the gated-BUFGCTRL CPU clock mux.
- Derives the Z80 CPU clock as clock enables from a single 28 MHz domain (mb_clk_28), so no clock muxing or BUFGCTRL is needed.
- Supports N binary speeds (3.5/7/14/28 MHz by default), per-speed contention stalling, glitch-free speed changes at a common phase boundary, and a saturating contention-cycle counter.
- Sits between the speed/contention logic and the CPU core and ULA timing.

Parameters:
- NUM_SPEEDS, 4, number of speeds (≥2). Speed s divides clk_28 by P(s) = 2^(CW-s), where CW = NUM_SPEEDS-1.
- SPEED_W, 2, width of the speed fields; 2^SPEED_W ≥ NUM_SPEEDS.
- CONTEND_MASK, 4'b0001, bit s=1 means speed s honours cpu_contend (default: 3.5 MHz only). Width NUM_SPEEDS.
- CNT_W, 16, width of the contention counter.

Ports:
- clk_28  input  1  28 MHz system clock (mb_clk_28 domain); all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- cpu_speed  input  SPEED_W  requested speed; values ≥ NUM_SPEEDS clamp to NUM_SPEEDS-1.
- cpu_contend  input  1  contention request, sampled only at rise points.
- contend_count_clr  input  1  synchronous clear of contend_count.
- cpu_clk_en  output  1  one-cycle pulse: CPU rising edge.
- cpu_clk_fall_en  output  1  one-cycle pulse: CPU falling edge.
- cpu_clk_lsb  output  1  level of the virtual CPU clock.
- active_speed  output  SPEED_W  speed currently in effect.
- speed_switch_pending  output  1  request differs from active_speed.
- contend_count  output  CNT_W  saturating count of stalled rise points.

Behaviour:
- Reset: all state cleared asynchronously; cnt=0. Every output resets to 0, active_speed=0.
- cnt: free-running CW-bit counter, +1 per cycle, wraps at 2^CW-1 → 0. It holds, not increments, during a stall.
- Rise point: for s<CW, rise when cnt[CW-s-1:0]==0 and fall when cnt[CW-s-1:0]==P(s)/2. For s=CW, rise and fall occur every cycle.
- Outputs are registered; cpu_clk_en and cpu_clk_fall_en assert the cycle after cnt takes the matching value (1-cycle latency).
- cpu_clk_lsb:
  - set 1 on a rise and cleared 0 on a fall;
  - at s=CW it toggles every cycle, starting at 1 on the first rise after reset.
- Contention:
  - Applies at a rise point when CONTEND_MASK[active_speed]=1 and cpu_contend=1.
  - Rise is suppressed (cpu_clk_en=0), cnt holds and cpu_clk_lsb stays 0.
  - contend_count increments by 1, saturating at 2^CNT_W-1.
  - Re-evaluated every cycle; the first cycle with cpu_contend=0 produces the rise.
- Contention ignored when CONTEND_MASK[active_speed]=0.
- Speed switch:
  - speed_switch_pending = (clamped cpu_speed != active_speed), registered.
  - active_speed loads the clamped request only in a cycle where cnt==2^CW-1 and no stall is active. The next cnt=0 is then a rise point common to all speeds.
  - This guarantees no runt or short phase.
  - A request that changes again before the boundary is superseded; the last value at the boundary wins.
- contend_count_clr has priority over an increment in the same cycle: the result is 0.
- Reset mid-stall or mid-switch aborts both; the block restarts at speed 0 with cnt=0.
- Invariant: cpu_clk_en and cpu_clk_fall_en are never both 1 in the same cycle, except at s=CW.

Test Plan:
- Speed 0 from reset, no contention:
  - cpu_clk_en pulses every 8 cycles, fall_en every 8 cycles offset by 4;
  - cpu_clk_lsb high 4 / low 4;
  - 10 rises in 80 cycles.
- Switch 0→2 requested at cnt=2:
  - pending=1 until cnt=7;
  - active_speed=2 at the boundary, then period 2;
  - no high or low phase shorter than the old phase during the transition.
- Contention at speed 0:
  - cpu_contend=1 for 5 cycles spanning a rise point;
  - the rise is delayed exactly 5 cycles, contend_count=5, cpu_clk_lsb stays 0 throughout.
- Contention at speed 1 (mask bit 0 only):
  - cpu_contend=1 continuously;
  - period stays 4 and contend_count stays 0.
- Saturation and clear:
  - CNT_W=4, contend for 20 rise points gives contend_count=15;
  - clr and contend together in one cycle gives 0.
- Edge cases:
  - Out-of-range request cpu_speed=3 with NUM_SPEEDS=3 clamps to 2.
  - reset asserted mid-stall: all outputs 0 immediately (asynchronous); after release the first rise occurs at cnt=0 at speed 0.

Source files
------------

// File: rtl/cpu_clock_enable_gen.sv
// CPU clock-enable generator for the 28 MHz domain.
// Produces the Z80 clock as rise/fall enables for a set of binary-divided
// speeds, with per-speed contention stalling, speed changes aligned to the
// common phase boundary, and a saturating count of stalled rise points.
module cpu_clock_enable_gen #(
  parameter int                  NUM_SPEEDS   = 4,
  parameter int                  SPEED_W      = 2,
  parameter logic [NUM_SPEEDS-1:0] CONTEND_MASK = 4'b0001,
  parameter int                  CNT_W        = 16
) (
  input  logic               clk_28,
  input  logic               reset,
  input  logic [SPEED_W-1:0] cpu_speed,
  input  logic               cpu_contend,
  input  logic               contend_count_clr,
  output logic               cpu_clk_en,
  output logic               cpu_clk_fall_en,
  output logic               cpu_clk_lsb,
  output logic [SPEED_W-1:0] active_speed,
  output logic               speed_switch_pending,
  output logic [CNT_W-1:0]   contend_count
);

  localparam int CW = NUM_SPEEDS - 1;
  localparam logic [SPEED_W-1:0] MAX_SPEED = SPEED_W'(CW);

  logic [CW-1:0]      cnt;
  logic [CW-1:0]      lo_mask;
  logic [CW-1:0]      half;
  logic [SPEED_W-1:0] req_clamped;
  logic [SPEED_W-1:0] next_speed;
  logic               at_max;
  logic               rise;
  logic               fall;
  logic               stall;
  logic               boundary;

  // Phase decode for the active speed, stall detection and boundary switch.
  // lo_mask selects the cnt bits that make up one period of the active speed;
  // at the fastest speed it is empty, so every cycle is a rise point.
  always_comb begin
    req_clamped = (cpu_speed > MAX_SPEED) ? MAX_SPEED : cpu_speed;
    lo_mask     = {CW{1'b1}} >> active_speed;
    half        = (lo_mask >> 1) + 1'b1;
    at_max      = (active_speed == MAX_SPEED);
    rise        = ((cnt & lo_mask) == '0);
    fall        = at_max ? 1'b1 : ((cnt & lo_mask) == half);
    stall       = rise & cpu_contend & CONTEND_MASK[active_speed];
    // A stall can only coincide with cnt at its maximum at the fastest speed,
    // so the switch waits until the stall has cleared.
    boundary    = (cnt == {CW{1'b1}}) & ~stall;
    next_speed  = boundary ? req_clamped : active_speed;
  end

  // Phase counter, registered enables and the virtual clock level.
  always_ff @(posedge clk_28 or posedge reset) begin
    if (reset) begin
      cnt             <= '0;
      cpu_clk_en      <= 1'b0;
      cpu_clk_fall_en <= 1'b0;
      cpu_clk_lsb     <= 1'b0;
    end else begin
      cnt             <= stall ? cnt : cnt + 1'b1;
      cpu_clk_en      <= rise & ~stall;
      cpu_clk_fall_en <= fall & ~stall;
      if (stall)
        cpu_clk_lsb <= 1'b0;
      else if (at_max)
        cpu_clk_lsb <= ~cpu_clk_lsb;
      else if (rise)
        cpu_clk_lsb <= 1'b1;
      else if (fall)
        cpu_clk_lsb <= 1'b0;
    end
  end

  // Speed selection: the request only takes effect at the phase boundary.
  // Pending compares against the post-update speed so it drops with the load.
  always_ff @(posedge clk_28 or posedge reset) begin
    if (reset) begin
      active_speed         <= '0;
      speed_switch_pending <= 1'b0;
    end else begin
      active_speed         <= next_speed;
      speed_switch_pending <= (req_clamped != next_speed);
    end
  end

  // Saturating count of stalled rise points; clear wins over increment.
  always_ff @(posedge clk_28 or posedge reset) begin
    if (reset)
      contend_count <= '0;
    else if (contend_count_clr)
      contend_count <= '0;
    else if (stall && (contend_count != {CNT_W{1'b1}}))
      contend_count <= contend_count + 1'b1;
  end

endmodule

// File: tb/tb_cpu_clock_enable_gen.sv
// Directed bench for cpu_clock_enable_gen: a vector table for the default
// four-speed build plus short sequences on a three-speed, 4-bit-counter build.
module tb_cpu_clock_enable_gen;

  logic       clk_28 = 1'b0;
  logic       reset;
  logic [1:0] cpu_speed;
  logic       cpu_contend;
  logic       contend_count_clr;

  logic        a_en, a_fall, a_lsb, a_pend;
  logic [1:0]  a_act;
  logic [15:0] a_cnt;
  logic        b_en, b_fall, b_lsb, b_pend;
  logic [1:0]  b_act;
  logic [3:0]  b_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk_28 = ~clk_28;

  cpu_clock_enable_gen dut_a (
    .clk_28(clk_28), .reset(reset), .cpu_speed(cpu_speed),
    .cpu_contend(cpu_contend), .contend_count_clr(contend_count_clr),
    .cpu_clk_en(a_en), .cpu_clk_fall_en(a_fall), .cpu_clk_lsb(a_lsb),
    .active_speed(a_act), .speed_switch_pending(a_pend), .contend_count(a_cnt)
  );

  cpu_clock_enable_gen #(
    .NUM_SPEEDS(3), .SPEED_W(2), .CONTEND_MASK(3'b001), .CNT_W(4)
  ) dut_b (
    .clk_28(clk_28), .reset(reset), .cpu_speed(cpu_speed),
    .cpu_contend(cpu_contend), .contend_count_clr(contend_count_clr),
    .cpu_clk_en(b_en), .cpu_clk_fall_en(b_fall), .cpu_clk_lsb(b_lsb),
    .active_speed(b_act), .speed_switch_pending(b_pend), .contend_count(b_cnt)
  );

  typedef struct {
    logic [1:0]  spd;
    logic        cont;
    logic        clr;
    logic        en;
    logic        fall;
    logic        lsb;
    logic [1:0]  act;
    logic        pend;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[56];

  function automatic vec_t mk(input logic [1:0] spd, input logic cont, input logic clr,
                              input logic en, input logic fall, input logic lsb,
                              input logic [1:0] act, input logic pend, input logic [15:0] cnt);
    vec_t v;
    v.spd = spd; v.cont = cont; v.clr = clr;
    v.en = en; v.fall = fall; v.lsb = lsb;
    v.act = act; v.pend = pend; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_28);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_speed = 2'd0; cpu_contend = 1'b0; contend_count_clr = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int rises, last, bad_gap;

    // Row k-1 holds the inputs driven before, and outputs expected after,
    // the k-th rising edge following reset release.
    for (int k = 1; k <= 16; k++) begin
      int c;
      c = (k - 1) % 8;
      tbl[k-1] = mk(2'd0, 0, 0, c == 0, c == 4, c < 4, 2'd0, 0, 16'd0);
    end
    // switch 0 -> 2 requested at cnt=2, takes effect at cnt=7
    tbl[16] = mk(2'd0, 0, 0, 1, 0, 1, 2'd0, 0, 16'd0);
    tbl[17] = mk(2'd0, 0, 0, 0, 0, 1, 2'd0, 0, 16'd0);
    tbl[18] = mk(2'd2, 0, 0, 0, 0, 1, 2'd0, 1, 16'd0);
    tbl[19] = mk(2'd2, 0, 0, 0, 0, 1, 2'd0, 1, 16'd0);
    tbl[20] = mk(2'd2, 0, 0, 0, 1, 0, 2'd0, 1, 16'd0);
    tbl[21] = mk(2'd2, 0, 0, 0, 0, 0, 2'd0, 1, 16'd0);
    tbl[22] = mk(2'd2, 0, 0, 0, 0, 0, 2'd0, 1, 16'd0);
    tbl[23] = mk(2'd2, 0, 0, 0, 0, 0, 2'd2, 0, 16'd0);
    tbl[24] = mk(2'd2, 0, 0, 1, 0, 1, 2'd2, 0, 16'd0);
    tbl[25] = mk(2'd2, 0, 0, 0, 1, 0, 2'd2, 0, 16'd0);
    tbl[26] = mk(2'd2, 0, 0, 1, 0, 1, 2'd2, 0, 16'd0);
    tbl[27] = mk(2'd2, 0, 0, 0, 1, 0, 2'd2, 0, 16'd0);
    // switch back to 0
    tbl[28] = mk(2'd0, 0, 0, 1, 0, 1, 2'd2, 1, 16'd0);
    tbl[29] = mk(2'd0, 0, 0, 0, 1, 0, 2'd2, 1, 16'd0);
    tbl[30] = mk(2'd0, 0, 0, 1, 0, 1, 2'd2, 1, 16'd0);
    tbl[31] = mk(2'd0, 0, 0, 0, 1, 0, 2'd0, 0, 16'd0);
    tbl[32] = mk(2'd0, 0, 0, 1, 0, 1, 2'd0, 0, 16'd0);
    tbl[33] = mk(2'd0, 0, 0, 0, 0, 1, 2'd0, 0, 16'd0);
    tbl[34] = mk(2'd0, 0, 0, 0, 0, 1, 2'd0, 0, 16'd0);
    tbl[35] = mk(2'd0, 0, 0, 0, 0, 1, 2'd0, 0, 16'd0);
    tbl[36] = mk(2'd0, 0, 0, 0, 1, 0, 2'd0, 0, 16'd0);
    tbl[37] = mk(2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 16'd0);
    tbl[38] = mk(2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 16'd0);
    tbl[39] = mk(2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 16'd0);
    // five-cycle contention over the cnt=0 rise point
    tbl[40] = mk(2'd0, 1, 0, 0, 0, 0, 2'd0, 0, 16'd1);
    tbl[41] = mk(2'd0, 1, 0, 0, 0, 0, 2'd0, 0, 16'd2);
    tbl[42] = mk(2'd0, 1, 0, 0, 0, 0, 2'd0, 0, 16'd3);
    tbl[43] = mk(2'd0, 1, 0, 0, 0, 0, 2'd0, 0, 16'd4);
    tbl[44] = mk(2'd0, 1, 0, 0, 0, 0, 2'd0, 0, 16'd5);
    tbl[45] = mk(2'd0, 0, 0, 1, 0, 1, 2'd0, 0, 16'd5);
    tbl[46] = mk(2'd0, 0, 0, 0, 0, 1, 2'd0, 0, 16'd5);
    tbl[47] = mk(2'd0, 0, 1, 0, 0, 1, 2'd0, 0, 16'd0);
    tbl[48] = mk(2'd0, 0, 0, 0, 0, 1, 2'd0, 0, 16'd0);
    tbl[49] = mk(2'd0, 0, 0, 0, 1, 0, 2'd0, 0, 16'd0);
    tbl[50] = mk(2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 16'd0);
    tbl[51] = mk(2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 16'd0);
    tbl[52] = mk(2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 16'd0);
    // clear and contend in the same cycle
    tbl[53] = mk(2'd0, 1, 0, 0, 0, 0, 2'd0, 0, 16'd1);
    tbl[54] = mk(2'd0, 1, 1, 0, 0, 0, 2'd0, 0, 16'd0);
    tbl[55] = mk(2'd0, 0, 0, 1, 0, 1, 2'd0, 0, 16'd0);

    reset = 1'b1;
    cpu_speed = 2'd0; cpu_contend = 1'b0; contend_count_clr = 1'b0;
    repeat (2) @(posedge clk_28);
    #1;
    chk("reset_outputs", {a_en, a_fall, a_lsb, a_pend, a_act, a_cnt}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 56; i++) begin
      cpu_speed = tbl[i].spd;
      cpu_contend = tbl[i].cont;
      contend_count_clr = tbl[i].clr;
      step();
      chk($sformatf("v%0d_en", i), a_en, tbl[i].en);
      chk($sformatf("v%0d_fall", i), a_fall, tbl[i].fall);
      chk($sformatf("v%0d_lsb", i), a_lsb, tbl[i].lsb);
      chk($sformatf("v%0d_act", i), a_act, tbl[i].act);
      chk($sformatf("v%0d_pend", i), a_pend, tbl[i].pend);
      chk($sformatf("v%0d_cnt", i), a_cnt, tbl[i].cnt);
    end

    // 10 rises in 80 cycles at speed 0
    do_reset();
    rises = 0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (a_en) rises++;
    end
    chk("rises_in_80", rises, 10);

    // speed 1 ignores contention: period 4, no stalls counted
    do_reset();
    cpu_speed = 2'd1;
    repeat (8) step();
    chk("speed1_active", a_act, 2'd1);
    cpu_contend = 1'b1;
    rises = 0; last = -1; bad_gap = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (a_en) begin
        if (last >= 0 && (k - last) != 4) bad_gap++;
        last = k;
        rises++;
      end
    end
    chk("speed1_rises", rises, 10);
    chk("speed1_gaps", bad_gap, 0);
    chk("speed1_no_count", a_cnt, 16'd0);

    // asynchronous reset in the middle of a stall
    do_reset();
    cpu_contend = 1'b1;
    repeat (3) step();
    chk("stall_count_pre", a_cnt, 16'd3);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outputs", {a_en, a_fall, a_lsb, a_pend, a_act, a_cnt}, 32'd0);
    cpu_contend = 1'b0;
    @(posedge clk_28);
    #1 reset = 1'b0;
    step();
    chk("post_reset_rise", {a_en, a_lsb, a_act}, {1'b1, 1'b1, 2'd0});
    repeat (4) step();
    chk("post_reset_fall", {a_fall, a_lsb}, {1'b1, 1'b0});

    // three-speed build: request 3 clamps to 2
    do_reset();
    cpu_speed = 2'd3;
    step();
    chk("clamp_pending", b_pend, 1'b1);
    repeat (3) step();
    chk("clamp_active", {b_act, b_pend}, {2'd2, 1'b0});
    step();
    chk("fast_edge1", {b_en, b_fall, b_lsb}, 3'b111);
    step();
    chk("fast_edge2", {b_en, b_fall, b_lsb}, 3'b110);

    // 4-bit counter saturates, then clear beats a concurrent increment
    do_reset();
    cpu_contend = 1'b1;
    repeat (20) step();
    chk("saturate", b_cnt, 4'd15);
    chk("saturate_no_rise", b_en, 1'b0);
    contend_count_clr = 1'b1;
    step();
    chk("clr_priority", b_cnt, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
